sonic_pcs_pattern_gen: RTL and testbench
========================================

// Module: sonic_pcs_pattern_gen
// PURPOSE
//  Avalon-ST source that generates 2-bit PCS test symbols (constant, alternating, PRBS7, counter).
//  Sits directly upstream of the PCS pattern-path timing adapter and drives its in_valid/in_data.
//  Honours in_ready backpressure; supports finite bursts or continuous run.
// PARAMETERS
//  LEN_W      16     width of burst_len / beat_count
//  PRBS_SEED  7'h7F  LFSR load value on every start; must be nonzero
// PORTS
//  clk         in   1      single clock for all logic
//  reset_n     in   1      asynchronous, active-low reset
//  start       in   1      1-cycle pulse: latch config and begin generation
//  stop        in   1      request end of generation after the next accepted beat
//  mode        in   2      00 CONST, 01 ALT, 10 PRBS7, 11 COUNT; sampled on start
//  const_pat   in   2      symbol for CONST mode; sampled on start
//  burst_len   in   LEN_W  beats per burst; 0 = continuous; sampled on start
//  out_valid   out  1      symbol valid (to timing adapter in_valid)
//  out_data    out  2      symbol (to timing adapter in_data)
//  out_ready   in   1      sink ready (from timing adapter in_ready)
//  busy        out  1      high in RUN and DONE
//  done        out  1      1-cycle pulse when a burst or run ends
//  beat_count  out  LEN_W  accepted beats since the last start; wraps modulo 2^LEN_W
//  err_inject  in   1      present only with SONIC_PCS_PG_ERR_INJECT_EN
// BEHAVIOUR
//  Reset: out_valid=0, out_data=2'b00, busy=0, done=0, beat_count=0, LFSR=PRBS_SEED, state IDLE.
//  States: IDLE -> RUN on start. RUN -> DONE on the terminating transfer. DONE -> IDLE after 1 cycle.
//  IDLE: start=1 and stop=0 latches config, clears beat_count, reloads LFSR, enters RUN.
//   start and stop together in IDLE: stop wins, block stays IDLE.
//  RUN: out_valid=1 on every cycle. First symbol is valid on the cycle after start (latency 1).
//   Transfer = out_valid & out_ready. On a transfer: beat_count++ and the next symbol is registered.
//   Without a transfer, out_data is held stable.
//  Terminating transfer: burst_len!=0 and beat_count==burst_len-1, or any transfer while stop_pend=1.
//   stop in RUN sets stop_pend. A transfer in the same cycle as stop terminates on that transfer.
//  After the terminating transfer: out_valid=0 next cycle. DONE asserts done for 1 cycle. start is ignored in RUN/DONE.
//  beat_count holds its final value in IDLE. In continuous mode it wraps 2^LEN_W-1 -> 0 without stopping.
//  Symbols (beat index k, from 0):
//   CONST: const_pat. ALT: 2'b01 for even k, 2'b10 for odd k.
//   COUNT: k[1:0], i.e. beat_count[1:0] at presentation.
//   PRBS7: x^7+x^6+1 LFSR, two steps per beat; step: b=l[6]^l[5], l<={l[5:0],b}.
//    data[1]=first step's b, data[0]=second step's b.
//  reset_n low mid-burst: immediate return to reset values; partial burst discarded, no done pulse.
// CONFIGURATION
//  SONIC_PCS_PG_ERR_INJECT_EN defined:
//   err_inject pulse sets inj_pend. The next symbol registered (start load or transfer advance) has data[0] inverted.
//   inj_pend then clears. Further pulses while inj_pend=1 are absorbed. The generator sequence itself is not perturbed.
//  Not defined: err_inject port and all related logic absent; symbols are never modified.
// STRUCTURE
//  Package sonic_pcs_pg_pkg: mode encodings, state encodings, PRBS7 width and tap positions, ALT symbol constants.
//  Sub-module sonic_pcs_pg_prbs7: 7-bit LFSR with load(seed) and advance (2 steps per call).
//   Emits the 2-bit symbol combinationally from the current state.
//  Top: FSM, burst counter, stop/inject pending flags, output register.
// TESTING
//  PRBS7, burst_len=4, out_ready=1: out_data = 00,00,00,10 on 4 consecutive cycles.
//   Then out_valid=0 and done pulses once; beat_count=4.
//  ALT, burst_len=3, out_ready low on cycle 2 for 3 cycles: out_data held at 2'b10 while stalled.
//   Sequence observed at transfers is 01,10,01.
//  CONST 2'b11, burst_len=0, stop after 5 transfers with out_ready=0 at stop:
//   exactly one more beat transfers when ready returns, then done; beat_count=6.
//  COUNT, LEN_W=4, continuous, 20 transfers: beat_count wraps 15->0. out_data cycles 00,01,10,11 with no stop.
//  reset_n pulled low mid-burst: out_valid and busy drop asynchronously, no done pulse.
//   A new start then replays the PRBS from seed (00,00,00,10).
//  With SONIC_PCS_PG_ERR_INJECT_EN, CONST 2'b00, err_inject at beat 2: exactly one beat shows 2'b01, all others 2'b00.

Source files
------------

// File: rtl/sonic_pcs_pg_pkg.sv
// -----------------------------------------------------------------------------
// sonic_pcs_pg_pkg
// Shared definitions for the PCS test-pattern generator: mode and state
// encodings, PRBS7 polynomial geometry, ALT symbol constants and the
// single-step LFSR helper used by the PRBS sub-module.
// -----------------------------------------------------------------------------
package sonic_pcs_pg_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'b00,
    MODE_ALT   = 2'b01,
    MODE_PRBS7 = 2'b10,
    MODE_COUNT = 2'b11
  } pg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } pg_state_e;

  // x^7 + x^6 + 1: feedback is l[6] ^ l[5]
  localparam int PRBS_W     = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;

  localparam logic [1:0] ALT_EVEN_SYM = 2'b01;
  localparam logic [1:0] ALT_ODD_SYM  = 2'b10;

  // One LFSR step; the new bit lands in l[0], so the fed-back bit of the
  // step is readable afterwards as result[0].
  function automatic logic [PRBS_W-1:0] prbs7_step(input logic [PRBS_W-1:0] l);
    return {l[PRBS_W-2:0], l[PRBS_TAP_A] ^ l[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/sonic_pcs_pg_prbs7.sv
// -----------------------------------------------------------------------------
// sonic_pcs_pg_prbs7
// 7-bit PRBS7 LFSR producing one 2-bit symbol per beat (two LFSR steps).
// sym is the symbol of the beat being registered this cycle: taken from the
// seed when load is high, otherwise from the current LFSR state. On load or
// advance the state moves two steps past whichever base produced sym.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (state -> SEED)
//   load          restart the sequence from SEED
//   advance       consume the current symbol and move two steps on
//   sym           2-bit symbol: [1] first step's feedback, [0] second's
// -----------------------------------------------------------------------------
module sonic_pcs_pg_prbs7
  import sonic_pcs_pg_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] sym
);

  logic [PRBS_W-1:0] lfsr_q;
  logic [PRBS_W-1:0] base;
  logic [PRBS_W-1:0] mid;
  logic [PRBS_W-1:0] fin;

  always_comb begin
    base = load ? SEED : lfsr_q;
    mid  = prbs7_step(base);
    fin  = prbs7_step(mid);
    sym  = {mid[0], fin[0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else if (load || advance) begin
      lfsr_q <= fin;
    end
  end

endmodule

// File: rtl/sonic_pcs_pattern_gen.sv
// -----------------------------------------------------------------------------
// sonic_pcs_pattern_gen
// Avalon-ST source of 2-bit PCS test symbols (CONST, ALT, PRBS7, COUNT) that
// feeds the PCS pattern-path timing adapter. Honours out_ready backpressure,
// runs finite bursts (burst_len != 0) or continuously until stop.
// Optional feature: define SONIC_PCS_PG_ERR_INJECT_EN to add the err_inject
// port, which flips data[0] of the next registered symbol once.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start, stop          start pulse (config sampled) / end-after-next-beat
//   mode, const_pat      pattern select and CONST symbol, sampled on start
//   burst_len            beats per burst, 0 = continuous, sampled on start
//   out_valid, out_data  Avalon-ST source side
//   out_ready            sink ready
//   busy, done           busy in RUN/DONE, 1-cycle done at end of run
//   beat_count           accepted beats since last start (wraps)
//   err_inject           (optional) error injection request
// -----------------------------------------------------------------------------
module sonic_pcs_pattern_gen
  import sonic_pcs_pg_pkg::*;
#(
  parameter int                LEN_W     = 16,
  parameter logic [PRBS_W-1:0] PRBS_SEED = 7'h7F
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [1:0]       const_pat,
  input  logic [LEN_W-1:0] burst_len,
  output logic             out_valid,
  output logic [1:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_count
`ifdef SONIC_PCS_PG_ERR_INJECT_EN
  ,
  input  logic             err_inject
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  pg_state_e        state_q, state_d;
  pg_mode_e         mode_q;
  logic [1:0]       cpat_q;
  logic [LEN_W-1:0] blen_q;
  logic [LEN_W-1:0] beat_count_q;
  logic             stop_pend_q;
  logic [1:0]       out_data_q;

  logic             start_ok;
  logic             xfer;
  logic             last_beat;
  logic             sym_load;
  logic             inj_apply;
  logic [1:0]       prbs_sym;
  pg_mode_e         sym_mode;
  logic [1:0]       sym_cpat;
  logic [1:0]       sym_idx;
  logic [1:0]       next_sym;

  function automatic logic [1:0] pick_symbol(input pg_mode_e   m,
                                             input logic [1:0] cpat,
                                             input logic [1:0] idx,
                                             input logic [1:0] prbs);
    logic [1:0] s;
    case (m)
      MODE_CONST: s = cpat;
      MODE_ALT:   s = idx[0] ? ALT_ODD_SYM : ALT_EVEN_SYM;
      MODE_PRBS7: s = prbs;
      default:    s = idx;
    endcase
    return s;
  endfunction

  // start with stop in the same cycle is refused
  assign start_ok  = (state_q == ST_IDLE) && start && !stop;
  assign xfer      = (state_q == ST_RUN) && out_ready;
  assign last_beat = xfer && (((blen_q != '0) && (beat_count_q == blen_q - LEN_ONE))
                              || stop_pend_q || stop);
  // a fresh symbol is registered on start and on every non-final transfer
  assign sym_load  = start_ok || (xfer && !last_beat);

  sonic_pcs_pg_prbs7 #(
    .SEED    (PRBS_SEED)
  ) u_prbs7 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .advance (xfer),
    .sym     (prbs_sym)
  );

  // Symbol selection: on start use the live config for beat 0, otherwise the
  // latched config for beat index beat_count+1.
  always_comb begin
    sym_mode = start_ok ? pg_mode_e'(mode) : mode_q;
    sym_cpat = start_ok ? const_pat : cpat_q;
    sym_idx  = start_ok ? 2'b00 : (beat_count_q[1:0] + 2'b01);
    next_sym = pick_symbol(sym_mode, sym_cpat, sym_idx, prbs_sym) ^ {1'b0, inj_apply};
  end

`ifdef SONIC_PCS_PG_ERR_INJECT_EN
  logic inj_pend_q;

  assign inj_apply = inj_pend_q && sym_load;

  // pulses arriving while a request is pending are absorbed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inj_pend_q <= 1'b0;
    end else if (inj_apply) begin
      inj_pend_q <= 1'b0;
    end else if (err_inject) begin
      inj_pend_q <= 1'b1;
    end
  end
`else
  assign inj_apply = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= MODE_CONST;
      cpat_q       <= 2'b00;
      blen_q       <= '0;
      beat_count_q <= '0;
      stop_pend_q  <= 1'b0;
      out_data_q   <= 2'b00;
    end else begin
      if (start_ok) begin
        mode_q       <= pg_mode_e'(mode);
        cpat_q       <= const_pat;
        blen_q       <= burst_len;
        beat_count_q <= '0;
        stop_pend_q  <= 1'b0;
      end else if (xfer) begin
        beat_count_q <= beat_count_q + LEN_ONE;
      end
      if (sym_load) begin
        out_data_q <= next_sym;
      end
      // stop without a transfer waits for the next accepted beat
      if (last_beat) begin
        stop_pend_q <= 1'b0;
      end else if ((state_q == ST_RUN) && stop) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

  assign out_data   = out_data_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_sonic_pcs_pattern_gen.sv
module tb_sonic_pcs_pattern_gen;

  localparam int LEN_W = 4;
`ifdef SONIC_PCS_PG_ERR_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [1:0]       const_pat;
  logic [LEN_W-1:0] burst_len;
  logic             out_valid;
  logic [1:0]       out_data;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] beat_count;
  logic             err_inject;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] prbs_tab [0:126];

  always #5 clk = ~clk;

  sonic_pcs_pattern_gen #(
    .LEN_W      (LEN_W),
    .PRBS_SEED  (7'h7F)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .const_pat  (const_pat),
    .burst_len  (burst_len),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
`ifdef SONIC_PCS_PG_ERR_INJECT_EN
    ,
    .err_inject (err_inject)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PRBS reference: serial bit stream of the polynomial, paired into symbols
  task automatic build_prbs();
    logic [6:0] r;
    bit bits [$];
    r = 7'h7F;
    for (int i = 0; i < 254; i++) begin
      bit nb;
      nb = r[6] ^ r[5];
      bits.push_back(nb);
      r = {r[5:0], nb};
    end
    for (int k = 0; k < 127; k++) prbs_tab[k] = {bits[2*k], bits[2*k+1]};
  endtask

  function automatic logic [1:0] exp_sym(input logic [1:0] m, input logic [1:0] cp, input int k);
    case (m)
      2'd0:    return cp;
      2'd1:    return (k % 2 == 0) ? 2'b01 : 2'b10;
      2'd2:    return prbs_tab[k % 127];
      default: return 2'(k % 4);
    endcase
  endfunction

  // One start..done run. Ready per cycle comes from rmask (bit c) or random.
  // stop is pulsed once when k reaches stop_after; err_inject at cycle inj_cyc.
  task automatic run_burst(input logic [1:0] m, input logic [1:0] cp, input int blen,
                           input logic [31:0] rmask, input bit rnd,
                           input int stop_after, input int inj_cyc);
    int k, c, inv_beat;
    bit stop_pm, stop_done, inj_pm, rdy, stp, term, inj_now;
    k = 0; c = 0; inv_beat = -1;
    stop_pm = 0; stop_done = 0; inj_pm = 0;
    start = 1'b1; mode = m; const_pat = cp; burst_len = blen[LEN_W-1:0];
    stop = 1'b0; out_ready = 1'b0; err_inject = 1'b0;
    @(negedge clk);
    start = 1'b0;
    forever begin
      chk("run_valid", 32'(out_valid), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_beat_count", 32'(beat_count), 32'(k % 16));
      chk("run_data", 32'(out_data), 32'(exp_sym(m, cp, k) ^ ((k == inv_beat) ? 2'b01 : 2'b00)));
      rdy     = rnd ? ($urandom_range(0, 3) != 0) : ((c < 32) ? rmask[c] : 1'b1);
      stp     = (stop_after >= 0) && (k >= stop_after) && !stop_done;
      inj_now = (c == inj_cyc);
      term    = rdy && (((blen != 0) && (k == blen - 1)) || stop_pm || stp);
      out_ready  = rdy;
      stop       = stp;
      err_inject = inj_now;
      start      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (rdy && !term && inj_pm) begin
        inv_beat = k + 1;
        inj_pm   = 0;
      end else if (inj_now) begin
        inj_pm = 1;
      end
      if (rdy) k++;
      if (stp) begin
        stop_done = 1;
        if (!rdy) stop_pm = 1;
      end
      c++;
      if (term) break;
      if (c > 1000) begin
        n_cmp++; n_err++;
        $error("FAIL run_timeout: observed %0d cycles expected termination", c);
        break;
      end
    end
    start = 1'b0; stop = 1'b0; err_inject = 1'b0;
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd1);
    chk("end_beat_count", 32'(beat_count), 32'(k % 16));
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_beat_count", 32'(beat_count), 32'(k % 16));
  endtask

  initial begin
    build_prbs();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; const_pat = 2'b00;
    burst_len = '0; out_ready = 1'b0; err_inject = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // PRBS7, burst 4, always ready
    run_burst(2'd2, 2'd0, 4, 32'hFFFF_FFFF, 1'b0, -1, -1);

    // start with stop in IDLE: no run, beat_count keeps 4
    start = 1'b1; stop = 1'b1; mode = 2'd1; burst_len = 4'd3;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    chk("startstop_valid", 32'(out_valid), 32'd0);
    chk("startstop_beat_count", 32'(beat_count), 32'd4);
    @(negedge clk);

    // ALT, burst 3, ready low for cycles 1..3
    run_burst(2'd1, 2'd0, 3, 32'hFFFF_FFF1, 1'b0, -1, -1);

    // CONST 11 continuous, stop after 5 transfers while not ready
    run_burst(2'd0, 2'd3, 0, 32'hFFFF_FF9F, 1'b0, 5, -1);

    // COUNT continuous: beat_count wraps 15 -> 0
    run_burst(2'd3, 2'd0, 0, 32'hFFFF_FFFF, 1'b0, 20, -1);

    // reset mid-burst
    start = 1'b1; mode = 2'd2; burst_len = 4'd10; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_beat_count", 32'(beat_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);
    run_burst(2'd2, 2'd0, 4, 32'hFFFF_FFFF, 1'b0, -1, -1);

    if (INJ_EN) begin
      // CONST 00: injection requested while beat 0 is presented lands on beat 2
      run_burst(2'd0, 2'd0, 6, 32'hFFFF_FFFF, 1'b0, -1, 0);
    end

    // randomized runs
    for (int it = 0; it < 12; it++) begin
      logic [1:0] rm, rc;
      int rb, rs, ri;
      rm = 2'($urandom_range(0, 3));
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        rb = $urandom_range(1, 15);
        rs = -1;
      end else begin
        rb = 0;
        rs = $urandom_range(0, 30);
      end
      ri = INJ_EN ? $urandom_range(0, 6) : -1;
      run_burst(rm, rc, rb, 32'hFFFF_FFFF, 1'b1, rs, ri);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
